// File: rtl/pat_frame_expander_if.sv
// Stream bundle for pat_frame_expander: pattern input stream plus the expanded output stream.
// The slave modport is the expander's view; the master modport is the source/sink side.
interface pat_frame_expander_if #(
  parameter int PATTERN_WIDTH = 32,
  parameter int OUTPUT_WIDTH  = 512
);
  logic [PATTERN_WIDTH-1:0] AXIS_IN_TDATA;
  logic                     AXIS_IN_TVALID;
  logic                     AXIS_IN_TREADY;
  logic [OUTPUT_WIDTH-1:0]  AXIS_OUT_TDATA;
  logic                     AXIS_OUT_TVALID;
  logic                     AXIS_OUT_TLAST;
  logic                     AXIS_OUT_TUSER;
  logic                     AXIS_OUT_TREADY;

  modport slave (
    input  AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_OUT_TREADY,
    output AXIS_IN_TREADY, AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TUSER
  );

  modport master (
    output AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_OUT_TREADY,
    input  AXIS_IN_TREADY, AXIS_OUT_TDATA, AXIS_OUT_TVALID, AXIS_OUT_TLAST, AXIS_OUT_TUSER
  );
endinterface

// File: rtl/pat_frame_expander.sv
// Replicates each input pattern across the output bus as a rows x cycles frame, with a one-deep
// prefetch slot for bubble-free frames. Optional macro PATGEN_ROW_INCREMENT_EN adds the row index to each row's lanes.
module pat_frame_expander #(
  parameter int PATTERN_WIDTH = 32,
  parameter int OUTPUT_WIDTH  = 512,
  parameter int CW            = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [CW-1:0]            cfg_cycles_per_row,
  input  logic [CW-1:0]            cfg_rows_per_frame,
  output logic [PATTERN_WIDTH-1:0] active_pattern,
  output logic                     busy,
  output logic [31:0]              frames_sent,
  pat_frame_expander_if.slave      axis
);
  localparam int NUM_LANES = OUTPUT_WIDTH / PATTERN_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [CW-1:0]            cyc, row, cyc_max, row_max;
  logic [CW-1:0]            pend_cyc_max, pend_row_max;
  logic [CW-1:0]            cfg_cyc_max, cfg_row_max;
  logic [PATTERN_WIDTH-1:0] pend_pat;
  logic                     pend_valid, tvalid;
  logic                     in_hs, out_hs, last, first, frame_end;
  logic [PATTERN_WIDTH-1:0] lane_val;
  logic [NUM_LANES-1:0][PATTERN_WIDTH-1:0] lanes;

  // A zero geometry field means one beat/row, so the stored maxima are count-1 clamped at 0.
  assign cfg_cyc_max = (cfg_cycles_per_row == '0) ? '0 : cfg_cycles_per_row - CW'(1);
  assign cfg_row_max = (cfg_rows_per_frame == '0) ? '0 : cfg_rows_per_frame - CW'(1);

  assign in_hs     = axis.AXIS_IN_TVALID & axis.AXIS_IN_TREADY;
  assign out_hs    = tvalid & axis.AXIS_OUT_TREADY;
  assign last      = (cyc == cyc_max);
  assign first     = (cyc == '0) && (row == '0);
  assign frame_end = out_hs & last & (row == row_max);

  // resetn is expected to be released synchronously to clk by the reset controller upstream.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      tvalid         <= 1'b0;
      pend_valid     <= 1'b0;
      pend_pat       <= '0;
      pend_cyc_max   <= '0;
      pend_row_max   <= '0;
      active_pattern <= '0;
      cyc_max        <= '0;
      row_max        <= '0;
      cyc            <= '0;
      row            <= '0;
      frames_sent    <= '0;
    end else if (state == IDLE) begin
      if (in_hs) begin
        active_pattern <= axis.AXIS_IN_TDATA;
        cyc_max        <= cfg_cyc_max;
        row_max        <= cfg_row_max;
        cyc            <= '0;
        row            <= '0;
        tvalid         <= 1'b1;
        state          <= RUN;
      end
    end else begin
      if (out_hs) begin
        if (!last) begin
          cyc <= cyc + CW'(1);
        end else if (row != row_max) begin
          cyc <= '0;
          row <= row + CW'(1);
        end else begin
          frames_sent <= frames_sent + 32'd1;
          cyc         <= '0;
          row         <= '0;
          if (pend_valid) begin
            active_pattern <= pend_pat;
            cyc_max        <= pend_cyc_max;
            row_max        <= pend_row_max;
            pend_valid     <= 1'b0;
          end else if (in_hs) begin
            active_pattern <= axis.AXIS_IN_TDATA;
            cyc_max        <= cfg_cyc_max;
            row_max        <= cfg_row_max;
          end else begin
            tvalid <= 1'b0;
            state  <= IDLE;
          end
        end
      end
      // Geometry is captured with the beat so later cfg changes cannot touch it.
      if (in_hs && !frame_end) begin
        pend_pat     <= axis.AXIS_IN_TDATA;
        pend_cyc_max <= cfg_cyc_max;
        pend_row_max <= cfg_row_max;
        pend_valid   <= 1'b1;
      end
    end
  end

`ifdef PATGEN_ROW_INCREMENT_EN
  assign lane_val = active_pattern + PATTERN_WIDTH'(row);
`else
  assign lane_val = active_pattern;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes[i] = lane_val;
  end

  assign axis.AXIS_OUT_TDATA  = lanes;
  assign axis.AXIS_OUT_TVALID = tvalid;
  assign axis.AXIS_OUT_TLAST  = last;
  assign axis.AXIS_OUT_TUSER  = first;
  assign axis.AXIS_IN_TREADY  = resetn & ~pend_valid;
  assign busy                 = (state == RUN) | pend_valid;
endmodule
